// File: rtl/fir_decim_avg_if.sv
// fir_decim_avg_if: sample stream in, averaged result out with valid/ready
interface fir_decim_avg_if #(
   parameter int WIDTH     = 30,
   parameter int OUT_WIDTH = 16
);
   logic signed [WIDTH-1:0]     din;
   logic                        din_valid;
   logic [3:0]                  dec_log2;
   logic                        sync_clr;
   logic signed [OUT_WIDTH-1:0] dout;
   logic                        dout_sat;
   logic                        dout_valid;
   logic                        dout_ready;
   logic                        overrun;
   modport master (
      output din, din_valid, dec_log2, sync_clr, dout_ready,
      input  dout, dout_sat, dout_valid, overrun
   );
   modport slave (
      input  din, din_valid, dec_log2, sync_clr, dout_ready,
      output dout, dout_sat, dout_valid, overrun
   );
endinterface

// File: rtl/fir_decim_avg.sv
// fir_decim_avg: 2^k boxcar decimator with gain shift, round-half-up, saturation and valid/ready output
module fir_decim_avg #(
   parameter int WIDTH     = 30,
   parameter int OUT_WIDTH = 16,
   parameter int MAX_LOG2  = 8,
   parameter int SHIFT     = 13
) (
   input logic           clk,
   input logic           rst,
   fir_decim_avg_if.slave bus
);
   localparam int AW = WIDTH + MAX_LOG2;
   localparam int CW = MAX_LOG2 + 1;
   localparam int RW = AW + 1 - SHIFT;
   localparam int SW = $clog2(MAX_LOG2 + SHIFT + 1);
   localparam logic signed [RW-1:0] OMAX = RW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [RW-1:0] OMIN = ~OMAX;
   typedef enum logic {IDLE, ACC} state_t;
   state_t                      state_q, state_d;
   logic signed [AW-1:0]        acc_q, acc_d, din_ext, sum;
   logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
   logic [3:0]                  k_q, k_d, k_in;
   logic                        fin_v_q, fin_v_d;
   logic signed [AW-1:0]        fin_acc_q, fin_acc_d;
   logic [3:0]                  fin_k_q, fin_k_d;
   logic                        r1_v_q;
   logic signed [RW-1:0]        r1_q, r1_d;
   logic [SW-1:0]               sh;
   logic [AW:0]                 rnd;
   logic signed [AW:0]          t;
   logic                        hi, lo, free, wr, drop, start;
   logic signed [OUT_WIDTH-1:0] dout_q, dout_d, sat_val;
   logic                        sat_q, sat_d, vld_q, vld_d, ovr_q, ovr_d;
   always_comb begin
      k_in      = (bus.dec_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : bus.dec_log2;
      din_ext   = {{MAX_LOG2{bus.din[WIDTH-1]}}, bus.din};
      sum       = acc_q + din_ext;
      cnt_inc   = cnt_q + 1'b1;
      start     = bus.din_valid && (state_q == IDLE || bus.sync_clr);
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      fin_v_d   = 1'b0;
      fin_acc_d = fin_acc_q;
      fin_k_d   = fin_k_q;
      if (start) begin
         k_d     = k_in;
         acc_d   = din_ext;
         cnt_d   = CW'(1);
         state_d = (k_in == 4'd0) ? IDLE : ACC;
         if (k_in == 4'd0) begin
            fin_v_d   = 1'b1;
            fin_acc_d = din_ext;
            fin_k_d   = 4'd0;
         end
      end else if (bus.sync_clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (state_q == ACC && bus.din_valid) begin
         acc_d = sum;
         cnt_d = cnt_inc;
         if (cnt_inc == (CW'(1) << k_q)) begin
            state_d   = IDLE;
            fin_v_d   = 1'b1;
            fin_acc_d = sum;
            fin_k_d   = k_q;
         end
      end
   end
   // Round stage: one bit of headroom above the accumulator so the bias add never wraps.
   always_comb begin
      sh   = SW'(fin_k_q) + SW'(SHIFT);
      rnd  = {{AW{1'b0}}, 1'b1} << (sh - 1'b1);
      t    = {fin_acc_q[AW-1], fin_acc_q} + rnd;
      r1_d = RW'(t >>> sh);
   end
   always_comb begin
      hi      = r1_q > OMAX;
      lo      = r1_q < OMIN;
      sat_val = hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : r1_q[OUT_WIDTH-1:0];
      free    = !vld_q || bus.dout_ready;
      wr      = r1_v_q && free;
      drop    = r1_v_q && !free;
      dout_d  = wr ? sat_val : dout_q;
      sat_d   = wr ? (hi | lo) : sat_q;
      vld_d   = wr | (vld_q & ~bus.dout_ready);
      ovr_d   = (ovr_q & ~bus.sync_clr) | drop;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         k_q       <= '0;
         fin_v_q   <= 1'b0;
         fin_acc_q <= '0;
         fin_k_q   <= '0;
         r1_v_q    <= 1'b0;
         r1_q      <= '0;
         dout_q    <= '0;
         sat_q     <= 1'b0;
         vld_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         fin_v_q   <= fin_v_d;
         fin_acc_q <= fin_acc_d;
         fin_k_q   <= fin_k_d;
         r1_v_q    <= fin_v_q;
         r1_q      <= r1_d;
         dout_q    <= dout_d;
         sat_q     <= sat_d;
         vld_q     <= vld_d;
         ovr_q     <= ovr_d;
      end
   end
   assign bus.dout       = dout_q;
   assign bus.dout_sat   = sat_q;
   assign bus.dout_valid = vld_q;
   assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_fir_decim_avg.sv
// tb_fir_decim_avg: vector table plus hand sequences, results checked through an output scoreboard
module tb_fir_decim_avg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   fir_decim_avg_if #(.WIDTH(30), .OUT_WIDTH(16)) bus ();
   fir_decim_avg dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {longint d; logic s;} exp_t;
   typedef struct {int k; longint din; longint exp; logic sat;} vec_t;
   exp_t sbq[$];
   vec_t tbl[10];
   int checks = 0;
   int errors = 0;
   task automatic chk(input string n, input longint a, input longint e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, a, e);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.dout_valid && bus.dout_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got %0d want none", bus.dout);
         end else begin
            e = sbq.pop_front();
            chk("dout", bus.dout, e.d);
            chk("dout_sat", bus.dout_sat, e.s);
         end
      end
   end
   task automatic put(input logic v, input longint d, input int k, input logic c);
      bus.din_valid = v;
      bus.din       = d[29:0];
      bus.dec_log2  = 4'(k);
      bus.sync_clr  = c;
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.sync_clr  = 1'b0;
   endtask
   task automatic push(input longint d, input logic s);
      exp_t e;
      e.d = d;
      e.s = s;
      sbq.push_back(e);
   endtask
   task automatic frame(input int k, input longint d, input longint exp, input logic s, input logic p);
      int n;
      n = 1 << (k > 8 ? 8 : k);
      for (int i = 0; i < n; i++) put(1'b1, d, k, 1'b0);
      if (p) push(exp, s);
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", sbq.size(), 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{3, 81920, 10, 1'b0};
      tbl[1] = '{0, 4096, 1, 1'b0};
      tbl[2] = '{0, 4095, 0, 1'b0};
      tbl[3] = '{0, -4096, 0, 1'b0};
      tbl[4] = '{0, -4097, -1, 1'b0};
      tbl[5] = '{0, 536870911, 32767, 1'b1};
      tbl[6] = '{0, -536870912, -32768, 1'b1};
      tbl[7] = '{2, -81920, -10, 1'b0};
      tbl[8] = '{8, 81920, 10, 1'b0};
      tbl[9] = '{15, 81920, 10, 1'b0};
      bus.din = '0;
      bus.din_valid = 1'b0;
      bus.dec_log2 = '0;
      bus.sync_clr = 1'b0;
      bus.dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", bus.dout, 0);
      chk("rst_sat", bus.dout_sat, 0);
      chk("rst_valid", bus.dout_valid, 0);
      chk("rst_overrun", bus.overrun, 0);
      rst = 1'b0;
      frame(3, 81920, 10, 1'b0, 1'b1);
      chk("lat_e0_valid", bus.dout_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_e1_valid", bus.dout_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_e2_valid", bus.dout_valid, 1);
      chk("lat_e2_dout", bus.dout, 10);
      drain();
      foreach (tbl[i]) frame(tbl[i].k, tbl[i].din, tbl[i].exp, tbl[i].sat, 1'b1);
      drain();
      bus.dout_ready = 1'b0;
      frame(1, 16384, 2, 1'b0, 1'b1);
      frame(1, 16384, 2, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_valid", bus.dout_valid, 1);
      chk("bp_dout", bus.dout, 2);
      chk("bp_overrun", bus.overrun, 1);
      bus.dout_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_accept_valid", bus.dout_valid, 0);
      chk("bp_overrun_sticky", bus.overrun, 1);
      put(1'b0, 0, 0, 1'b1);
      chk("clr_overrun", bus.overrun, 0);
      drain();
      put(1'b1, 32768, 2, 1'b0);
      for (int i = 0; i < 3; i++) put(1'b1, 32768, 0, 1'b0);
      push(4, 1'b0);
      put(1'b1, 8192, 0, 1'b0);
      push(1, 1'b0);
      drain();
      put(1'b1, 1000000, 2, 1'b0);
      put(1'b1, 1000000, 2, 1'b0);
      put(1'b1, 32768, 2, 1'b1);
      for (int i = 0; i < 3; i++) put(1'b1, 32768, 0, 1'b0);
      push(4, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 32768, 2, 1'b0);
         if (i == 3) push(4, 1'b0);
         put(1'b0, 999999, 0, 1'b0);
      end
      drain();
      bus.dout_ready = 1'b0;
      put(1'b1, 4096, 0, 1'b0);
      put(1'b1, 4096, 0, 1'b0);
      for (int i = 0; i < 3; i++) put(1'b1, 81920, 3, 1'b0);
      chk("pre_rst_valid", bus.dout_valid, 1);
      chk("pre_rst_overrun", bus.overrun, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_dout", bus.dout, 0);
      chk("mid_rst_valid", bus.dout_valid, 0);
      chk("mid_rst_sat", bus.dout_sat, 0);
      chk("mid_rst_overrun", bus.overrun, 0);
      rst = 1'b0;
      bus.dout_ready = 1'b1;
      frame(3, 81920, 10, 1'b0, 1'b1);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_decim_avg.md
# fir_decim_avg

Decimating boxcar averager that sits directly downstream of the FIR low-pass stage in the ADC signal path. It accumulates 2^k consecutive signed FIR outputs, divides by the frame length, and applies a fixed gain-normalising shift with round-half-up. It saturates the result to the output width and presents it on a valid/ready interface to the demodulation/logging logic.

## Interface
- WIDTH, 30, input sample width (FIR output width: 14-bit ADC + 16-bit coeff growth)
- OUT_WIDTH, 16, output sample width
- MAX_LOG2, 8, maximum decimation exponent; accumulator width = WIDTH+MAX_LOG2
- SHIFT, 13, extra right shift removing FIR DC gain (coeff sum 32766 ≈ 2^15, keeps 2 guard bits)

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  WIDTH  signed FIR output sample
- din_valid  in  1  din qualifier; samples with din_valid=0 are ignored
- dec_log2  in  4  decimation exponent k; frame length 2^k; values > MAX_LOG2 clamp to MAX_LOG2
- sync_clr  in  1  synchronous frame restart; discards the partial frame and clears overrun
- dout  out  OUT_WIDTH  signed averaged sample
- dout_sat  out  1  dout was clipped; valid while dout_valid
- dout_valid  out  1  output holding register occupied
- dout_ready  in  1  consumer accept
- overrun  out  1  sticky: a completed result was dropped

## Operation
- Reset values: dout=0, dout_sat=0, dout_valid=0, overrun=0, accumulator=0, sample count=0, state=IDLE.
- FSM states:
  - IDLE: waits for a valid sample.
  - ACC: frame in progress.
- IDLE + din_valid:
  - latch k_lat = clamp(dec_log2).
  - acc = sign-extended din; cnt = 1.
  - if 2^k_lat == 1, the frame completes immediately and the FSM stays IDLE.
  - otherwise go to ACC.
- ACC + din_valid:
  - acc += din; cnt += 1.
  - when cnt reaches 2^k_lat, the frame completes and the FSM returns to IDLE.
- dec_log2 is sampled only at the frame's first sample. Changes mid-frame have no effect until the next frame.
- Frame completion launches a 2-stage pipe:
  - R1 (round): t = acc + 2^(k_lat+SHIFT-1); r = t >>> (k_lat+SHIFT), arithmetic shift.
  - R2 (saturate): if r > 2^(OUT_WIDTH-1)-1, dout = max and sat=1. If r < -2^(OUT_WIDTH-1), dout = min and sat=1. Otherwise dout = r and sat=0.
- Internal rounding add is one bit wider than the accumulator; no wrap is permitted anywhere.
- Output handshake:
  - result is written into the holding register when the register is empty, or when dout_valid && dout_ready in the same cycle (accept-and-replace, no overrun).
  - if the register is full and not being accepted, the new result is dropped and overrun is set.
  - the held dout/dout_sat stay stable until accepted.
  - dout_valid clears on accept when no new result arrives.
- sync_clr:
  - accumulator and count are discarded; FSM goes to IDLE; overrun clears.
  - a din_valid sample in the same cycle becomes the first sample of the new frame, with dec_log2 latched that cycle.
  - results already in R1/R2 or the holding register are kept.
- rst mid-operation: all state returns to reset values and in-flight results are lost.

## Timing
- Throughput: one input per cycle.
- Latency: dout_valid rises 2 cycles after the clk edge that captures the frame's final sample, provided the holding register is free.
- With k=0, one result per valid sample at full rate. A stalled consumer for one cycle then causes an overrun.
- dout_ready is combinationally ignored for data; acceptance happens on the clk edge where dout_valid && dout_ready.

## Test plan
- Basic average: dec_log2=3, 8 valid samples of din=81920 → sum 655360, >>>16 → dout=10, dout_sat=0, dout_valid 2 cycles after the 8th sample.
- Rounding, k=0:
  - din=4096 → 1; din=4095 → 0.
  - din=-4096 → 0; din=-4097 → -1.
  - one result per cycle with dout_ready=1.
- Saturation, k=0:
  - din=536870911 → dout=32767, dout_sat=1.
  - din=-536870912 → dout=-32768, dout_sat=1.
- Backpressure:
  - dout_ready=0, k=1, four samples of 16384 → first result 2 held; second result dropped; overrun=1.
  - raising dout_ready accepts 2 and then drops dout_valid.
  - sync_clr clears overrun.
- Frame control:
  - dec_log2 changed 2→0 mid-frame → the current frame still completes after 4 samples, and the next frame uses k=0.
  - sync_clr after 2 of 4 samples, with din_valid in the same cycle → that sample starts a new 4-sample frame.
  - din_valid gaps do not advance the count.
- Reset mid-frame: rst asserted after 3 of 8 samples → all outputs return to 0 next cycle. The next 8 samples of 81920 yield exactly dout=10.
